// File: rtl/alu_acc_ctrl.sv
// ----------------------------------------------------------------------------
// alu_acc_ctrl
//   Command-side controller for a combinational WIDTH-bit ALU. An accumulator
//   feeds ALU in_a. Each command is taken over a valid/ready handshake,
//   executed in one EXEC cycle, written back to the accumulator (unless
//   skipped by cmd_skipz on a zero accumulator), and returned on a
//   valid/ready response channel. Sequence: IDLE -> EXEC -> RESP -> IDLE.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//   cmd_op, cmd_data, cmd_skipz  command fields, sampled at accept
//   alu_opcode, alu_in_a/b       ALU operands (in_a is always the accumulator)
//   alu_result, alu_a_is_zero    ALU results
//   rsp_valid/rsp_ready          response handshake
//   rsp_data, rsp_skipped        accumulator after command, skip flag
//   cmd_count                    completed commands, wraps 0xFFFF -> 0
// ----------------------------------------------------------------------------
module alu_acc_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_skipz,
    output logic [2:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_in_a,
    output logic [WIDTH-1:0] alu_in_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_a_is_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_skipped,
    output logic [15:0]      cmd_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic             skipz_q;
    logic [15:0]      count_q;

    assign alu_in_a  = acc;
    assign cmd_count = count_q;

    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // takes effect on the edge it is sampled; every state register is listed
    // so a reset mid-command fully aborts it.
    // NOTE: all state uses non-blocking assignments so each branch reads the
    // pre-edge values (e.g. rsp_data sees the old acc when skipping).
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            skipz_q     <= 1'b0;
            cmd_ready   <= 1'b0;
            alu_opcode  <= 3'b000;
            alu_in_b    <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_skipped <= 1'b0;
            count_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        // Command is latched straight into the ALU operand
                        // registers so it is presented throughout EXEC and
                        // held afterwards.
                        alu_opcode <= cmd_op;
                        alu_in_b   <= cmd_data;
                        skipz_q    <= cmd_skipz;
                        cmd_ready  <= 1'b0;
                        state      <= EXEC;
                    end else begin
                        // Raises ready on the first cycle after reset release.
                        cmd_ready <= 1'b1;
                    end
                end

                EXEC: begin
                    if (skipz_q && alu_a_is_zero) begin
                        rsp_data    <= acc;
                        rsp_skipped <= 1'b1;
                    end else begin
                        acc         <= alu_result;
                        rsp_data    <= alu_result;
                        rsp_skipped <= 1'b0;
                    end
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        count_q   <= count_q + 16'd1;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    cmd_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
